execute_stage: RTL and testbench

Execute stage of the five-stage pipeline. Sits directly downstream of the decode latch: consumes the latched operands and control, produces the ALU result, write-select and next-PC redirect for the execute latch and fetch. Adds an iterative 32-cycle unsigned multiplier (MULTU) with architectural HI/LO registers and a stall output to the hazard unit.

---
 rtl/execute_stage_pkg.sv | 19 +
 rtl/execute_stage_if.sv | 28 ++
 rtl/execute_stage_multu_unit.sv | 84 ++++++++
 rtl/execute_stage.sv | 67 ++++++
 tb/tb_execute_stage.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/execute_stage_pkg.sv
// Shared types for the execute stage: ALU and multiply/divide opcodes, register and word types.
// Also holds the multiplier FSM state encoding and the iteration count.
// Pure declarations; no timing or backpressure of its own.
package execute_stage_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;

  typedef enum logic [1:0] {MD_NONE, MD_MULTU, MD_MFHI, MD_MFLO} mdop_t;

  typedef enum logic [1:0] {MU_IDLE, MU_BUSY, MU_DONE} mu_state_t;

  localparam regbits_t LINK_REG  = 5'd31;
  localparam int       MUL_ITERS = 32;
endpackage

// File: rtl/execute_stage_if.sv
// Bundle between the decode latch, the execute stage and the execute latch / fetch / hazard unit.
// Wires only: no latency added here.
// Stalling is signalled by the stage through ex_stall; no other flow control.
interface execute_stage_if;
  import execute_stage_pkg::*;

  logic     en, flush;
  word_t    porta, rdat2, extout, pc_plus_4, jaddr;
  logic     ALUSrc, Branch, bne, Jump, JR, JAL, regDst;
  aluop_t   ALUop;
  mdop_t    mdop;
  regbits_t Rd, Rt;
  word_t    result, npc, hi, lo;
  logic     zero, redirect, ex_stall;
  regbits_t wsel;

  modport stage (
    input  en, flush, porta, rdat2, extout, pc_plus_4, jaddr,
           ALUSrc, Branch, bne, Jump, JR, JAL, regDst, ALUop, mdop, Rd, Rt,
    output result, zero, wsel, redirect, npc, ex_stall, hi, lo
  );

  modport tb (
    output en, flush, porta, rdat2, extout, pc_plus_4, jaddr,
           ALUSrc, Branch, bne, Jump, JR, JAL, regDst, ALUop, mdop, Rd, Rt,
    input  result, zero, wsel, redirect, npc, ex_stall, hi, lo
  );
endinterface

// File: rtl/execute_stage_multu_unit.sv
// Iterative shift-add 32x32 unsigned multiplier owning the architectural HI/LO registers.
// 1 load cycle + 32 iteration cycles; HI/LO written on the edge ending the last iteration.
// busy holds the pipeline from the start request until HI/LO are committed; abort drops the operation.
module multu_unit
  import execute_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
  input  logic  abort,
  input  logic  advance,
  input  word_t mcand_in,
  input  word_t mplier_in,
  output logic  busy,
  output word_t hi,
  output word_t lo
);
  mu_state_t   state, state_nxt;
  logic [4:0]  cnt;
  word_t       mcand, mplier;
  logic [63:0] acc, acc_step;
  logic [32:0] upper_sum;
  logic        last_iter;

  // Add into the upper half keeping the carry, then shift the whole accumulator right.
  always_comb begin
    upper_sum = {1'b0, acc[63:32]} + (mplier[0] ? {1'b0, mcand} : 33'd0);
    acc_step  = {upper_sum, acc[31:1]};
    last_iter = (cnt == 5'(MUL_ITERS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= MU_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MU_IDLE: if (start && !abort) state_nxt = MU_BUSY;
      MU_BUSY: begin
        if (abort)          state_nxt = MU_IDLE;
        else if (last_iter) state_nxt = MU_DONE;
      end
      MU_DONE: if (abort || advance) state_nxt = MU_IDLE;
      default: state_nxt = MU_IDLE;
    endcase
  end

  always_comb begin
    busy = ((state == MU_IDLE) && start && !abort) || (state == MU_BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        MU_IDLE: begin
          if (start && !abort) begin
            mcand  <= mcand_in;
            mplier <= mplier_in;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        MU_BUSY: begin
          if (!abort) begin
            acc    <= acc_step;
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
            if (last_iter) {hi, lo} <= acc_step;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU, branch/jump resolution, write-select and the MULTU/MFHI/MFLO path.
// ALU, redirect and wsel are combinational; MULTU stalls 33 cycles via ex_stall.
// Redirect is suppressed while stalled or flushed; the hazard unit owns all holding.
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  execute_stage_if.stage eif
);
  word_t portb, alu_out, br_target, mul_hi, mul_lo, npc_sel;
  logic  taken, mul_busy;

  always_comb begin
    portb = eif.ALUSrc ? eif.extout : eif.rdat2;
    case (eif.ALUop)
      ALU_SLL:  alu_out = eif.porta << portb[4:0];
      ALU_SRL:  alu_out = eif.porta >> portb[4:0];
      ALU_ADD:  alu_out = eif.porta + portb;
      ALU_SUB:  alu_out = eif.porta - portb;
      ALU_AND:  alu_out = eif.porta & portb;
      ALU_OR:   alu_out = eif.porta | portb;
      ALU_XOR:  alu_out = eif.porta ^ portb;
      ALU_NOR:  alu_out = ~(eif.porta | portb);
      ALU_SLT:  alu_out = {31'd0, $signed(eif.porta) < $signed(portb)};
      ALU_SLTU: alu_out = {31'd0, eif.porta < portb};
      default:  alu_out = '0;
    endcase
  end

  multu_unit u_multu (
    .clk       (CLK),
    .rst       (RST),
    .start     (eif.mdop == MD_MULTU),
    .abort     (eif.flush),
    .advance   (eif.en),
    .mcand_in  (eif.porta),
    .mplier_in (eif.rdat2),
    .busy      (mul_busy),
    .hi        (mul_hi),
    .lo        (mul_lo)
  );

  // jaddr already arrives as a full word address; JR takes priority over all other targets.
  always_comb begin
    taken     = eif.Branch && ((alu_out == '0) ^ eif.bne);
    br_target = eif.pc_plus_4 + (eif.extout << 2);
    if (eif.JR)                    npc_sel = eif.porta;
    else if (eif.Jump || eif.JAL)  npc_sel = eif.jaddr;
    else                           npc_sel = br_target;
  end

  always_comb begin
    if (eif.JAL)                  eif.result = eif.pc_plus_4;
    else if (eif.mdop == MD_MFHI) eif.result = mul_hi;
    else if (eif.mdop == MD_MFLO) eif.result = mul_lo;
    else                          eif.result = alu_out;
  end

  assign eif.zero     = (alu_out == '0);
  assign eif.wsel     = eif.JAL ? LINK_REG : (eif.regDst ? eif.Rd : eif.Rt);
  assign eif.npc      = npc_sel;
  assign eif.redirect = (taken || eif.Jump || eif.JAL || eif.JR) && !mul_busy && !eif.flush;
  assign eif.ex_stall = mul_busy;
  assign eif.hi       = mul_hi;
  assign eif.lo       = mul_lo;
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU/branch/jump vectors and MULTU timing, flush and reset cases.
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  int   n_cmp = 0;
  int   n_err = 0;

  execute_stage_if eif ();

  execute_stage dut (
    .CLK (CLK),
    .RST (RST),
    .eif (eif)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    eif.en = 1'b1;      eif.flush = 1'b0;
    eif.porta = '0;     eif.rdat2 = '0;   eif.extout = '0;
    eif.pc_plus_4 = '0; eif.jaddr = '0;
    eif.ALUSrc = 1'b0;  eif.Branch = 1'b0; eif.bne = 1'b0;
    eif.Jump = 1'b0;    eif.JR = 1'b0;     eif.JAL = 1'b0;  eif.regDst = 1'b0;
    eif.ALUop = ALU_ADD; eif.mdop = MD_NONE;
    eif.Rd = '0;        eif.Rt = '0;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Counts consecutive stall cycles from the current cycle; returns at the first non-stall negedge.
  task automatic count_stall(output int cycles);
    bit stop;
    cycles = 0;
    stop = 1'b0;
    for (int i = 0; i < 100 && !stop; i++) begin
      @(negedge CLK);
      if (eif.ex_stall) begin
        cycles++;
        @(posedge CLK);
        #1;
      end else begin
        stop = 1'b1;
      end
    end
  endtask

  int cyc;

  initial begin
    clear_inputs();
    RST = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge CLK);
    check("rst_hi", eif.hi, 0);
    check("rst_lo", eif.lo, 0);
    check("rst_stall", eif.ex_stall, 0);
    next_cycle();
    RST = 1'b0;

    // ADD wraps into the sign bit
    eif.ALUop = ALU_ADD; eif.porta = 32'h7FFF_FFFF; eif.ALUSrc = 1'b1; eif.extout = 32'h1;
    @(negedge CLK);
    check("add_res", eif.result, 32'h8000_0000);
    check("add_zero", eif.zero, 0);
    check("add_redir", eif.redirect, 0);

    clear_inputs(); next_cycle();
    eif.ALUop = ALU_SUB; eif.porta = 0; eif.rdat2 = 1;
    @(negedge CLK);
    check("sub_wrap", eif.result, 32'hFFFF_FFFF);

    // BEQ taken / BNE not taken
    clear_inputs(); next_cycle();
    eif.Branch = 1'b1; eif.ALUop = ALU_SUB; eif.porta = 5; eif.rdat2 = 5;
    eif.pc_plus_4 = 32'h100; eif.extout = 3;
    @(negedge CLK);
    check("beq_zero", eif.zero, 1);
    check("beq_redir", eif.redirect, 1);
    check("beq_npc", eif.npc, 32'h10C);
    eif.flush = 1'b1;
    @(negedge CLK);
    check("beq_flush_redir", eif.redirect, 0);
    eif.flush = 1'b0; eif.bne = 1'b1;
    @(negedge CLK);
    check("bne_redir", eif.redirect, 0);

    // JAL and JR
    clear_inputs(); next_cycle();
    eif.JAL = 1'b1; eif.pc_plus_4 = 32'h40; eif.jaddr = 32'h200; eif.Rd = 5'd3; eif.regDst = 1'b1;
    @(negedge CLK);
    check("jal_res", eif.result, 32'h40);
    check("jal_wsel", eif.wsel, 31);
    check("jal_npc", eif.npc, 32'h200);
    check("jal_redir", eif.redirect, 1);
    clear_inputs(); next_cycle();
    eif.JR = 1'b1; eif.porta = 32'h300; eif.jaddr = 32'h200;
    @(negedge CLK);
    check("jr_npc", eif.npc, 32'h300);
    check("jr_redir", eif.redirect, 1);

    // Remaining ALU ops and write-select
    clear_inputs(); next_cycle();
    eif.porta = 32'hFFFF_FFFF; eif.rdat2 = 1; eif.ALUop = ALU_SLT;
    eif.regDst = 1'b1; eif.Rd = 5'd7; eif.Rt = 5'd9;
    @(negedge CLK);
    check("slt", eif.result, 1);
    check("wsel_rd", eif.wsel, 7);
    eif.ALUop = ALU_SLTU; eif.regDst = 1'b0;
    @(negedge CLK);
    check("sltu", eif.result, 0);
    check("sltu_zero", eif.zero, 1);
    check("wsel_rt", eif.wsel, 9);
    eif.ALUop = ALU_NOR; eif.porta = 32'h0F0F_0F0F; eif.rdat2 = 32'h00FF_00FF;
    @(negedge CLK);
    check("nor", eif.result, 32'hF000_F000);
    eif.ALUop = ALU_XOR;
    @(negedge CLK);
    check("xor", eif.result, 32'h0FF0_0FF0);
    eif.ALUop = ALU_SRL; eif.porta = 32'h8000_0000; eif.ALUSrc = 1'b1; eif.extout = 32'h1F;
    @(negedge CLK);
    check("srl", eif.result, 1);
    eif.ALUop = ALU_SLL; eif.porta = 1; eif.extout = 32'h24;
    @(negedge CLK);
    check("sll", eif.result, 32'h10);

    // MULTU 0xFFFFFFFF x 2
    clear_inputs(); next_cycle();
    eif.mdop = MD_MULTU; eif.porta = 32'hFFFF_FFFF; eif.rdat2 = 2;
    count_stall(cyc);
    check("mul1_stall_cycles", cyc, 33);
    check("mul1_hi", eif.hi, 1);
    check("mul1_lo", eif.lo, 32'hFFFF_FFFE);
    next_cycle();
    eif.mdop = MD_MFLO;
    @(negedge CLK);
    check("mflo", eif.result, 32'hFFFF_FFFE);
    check("mflo_stall", eif.ex_stall, 0);
    eif.mdop = MD_MFHI;
    @(negedge CLK);
    check("mfhi", eif.result, 1);

    // MULTU 3x4 flushed in cycle 10
    clear_inputs(); next_cycle();
    eif.mdop = MD_MULTU; eif.porta = 3; eif.rdat2 = 4;
    repeat (10) next_cycle();
    eif.flush = 1'b1; eif.mdop = MD_NONE;
    next_cycle();
    eif.flush = 1'b0;
    @(negedge CLK);
    check("flush_stall", eif.ex_stall, 0);
    repeat (40) next_cycle();
    check("flush_hi", eif.hi, 1);
    check("flush_lo", eif.lo, 32'hFFFF_FFFE);

    // flush arriving together with MULTU: no load
    eif.mdop = MD_MULTU; eif.flush = 1'b1; eif.porta = 5; eif.rdat2 = 5;
    @(negedge CLK);
    check("flush_start_stall", eif.ex_stall, 0);
    next_cycle();
    eif.flush = 1'b0; eif.mdop = MD_NONE;
    @(negedge CLK);
    check("flush_start_idle", eif.ex_stall, 0);

    // MULTU interrupted by reset in cycle 20
    clear_inputs(); next_cycle();
    eif.mdop = MD_MULTU; eif.porta = 7; eif.rdat2 = 6;
    repeat (20) next_cycle();
    RST = 1'b1; eif.mdop = MD_NONE;
    next_cycle();
    RST = 1'b0;
    @(negedge CLK);
    check("rst_mid_hi", eif.hi, 0);
    check("rst_mid_lo", eif.lo, 0);
    check("rst_mid_stall", eif.ex_stall, 0);

    // Redriven MULTU, then held in DONE with en low
    next_cycle();
    eif.mdop = MD_MULTU; eif.porta = 32'h1234_5678; eif.rdat2 = 32'h10; eif.en = 1'b0;
    count_stall(cyc);
    check("mul2_stall_cycles", cyc, 33);
    check("mul2_hi", eif.hi, 1);
    check("mul2_lo", eif.lo, 32'h2345_6780);
    next_cycle();
    next_cycle();
    @(negedge CLK);
    check("done_hold_stall", eif.ex_stall, 0);
    check("done_hold_lo", eif.lo, 32'h2345_6780);
    eif.en = 1'b1;
    next_cycle();
    eif.mdop = MD_MFHI;
    @(negedge CLK);
    check("mul2_mfhi", eif.result, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
